// File: rtl/seq_cla_divider.sv
// Iterative restoring divider, one quotient bit per clock, trial subtraction on a 4-bit-group CLA.
// Optional two's-complement mode: define SEQ_CLA_DIVIDER_SIGNED_EN (adds a FIX sign-correction cycle).
module seq_cla_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SEQ_CLA_DIVIDER_SIGNED_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_FIX = 2'd2, S_DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd3} state_t;
`endif

    // Returns {carry_out, sum}; carries are fully expanded inside each 4-bit group and
    // only the group generate/propagate terms ripple from group to group.
    function automatic logic [WIDTH:0] cla_add(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic             cin);
        logic [WIDTH-1:0] sum;
        logic [3:0]       g;
        logic [3:0]       p;
        logic [3:0]       c;
        logic             gg;
        logic             pp;
        logic             cgrp;
        cgrp = cin;
        sum  = {WIDTH{1'b0}};
        for (int j = 0; j < WIDTH / 4; j++) begin
            g    = a[4*j +: 4] & b[4*j +: 4];
            p    = a[4*j +: 4] ^ b[4*j +: 4];
            c[0] = cgrp;
            c[1] = g[0] | (p[0] & cgrp);
            c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cgrp);
            c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cgrp);
            sum[4*j +: 4] = p ^ c;
            gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
            pp   = &p;
            cgrp = gg | (pp & cgrp);
        end
        return {cgrp, sum};
    endfunction

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        logic [WIDTH:0] t;
        t = cla_add(~x, {WIDTH{1'b0}}, 1'b1);
        return t[WIDTH-1:0];
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   r_sh_s;
    logic [WIDTH:0]   sub_s;
    logic             nb_s;
    logic [WIDTH-1:0] r_new_s;
    logic [WIDTH-1:0] q_new_s;
    logic [WIDTH-1:0] dvd_mag_s;
    logic [WIDTH-1:0] dsr_mag_s;

    // The stored remainder is always below the divisor, so only the shifted value needs the extra bit.
    assign r_sh_s  = {r_q, q_q[WIDTH-1]};
    assign sub_s   = cla_add(r_sh_s[WIDTH-1:0], ~dsr_q, 1'b1);
    assign nb_s    = r_sh_s[WIDTH] | sub_s[WIDTH];
    assign r_new_s = nb_s ? sub_s[WIDTH-1:0] : r_sh_s[WIDTH-1:0];
    assign q_new_s = {q_q[WIDTH-2:0], nb_s};

`ifdef SEQ_CLA_DIVIDER_SIGNED_EN
    logic qneg_q, qneg_d;
    logic rneg_q, rneg_d;
    assign dvd_mag_s = dividend[WIDTH-1] ? negate(dividend) : dividend;
    assign dsr_mag_s = divisor[WIDTH-1]  ? negate(divisor)  : divisor;

    // Sign-correction flags captured with the operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else begin
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
        end
    end
`else
    assign dvd_mag_s = dividend;
    assign dsr_mag_s = divisor;
`endif

    // Next-state, datapath and result update.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        dsr_d   = dsr_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
`ifdef SEQ_CLA_DIVIDER_SIGNED_EN
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (divisor == {WIDTH{1'b0}}) begin
                        state_d = S_DONE;
                        quo_d   = {WIDTH{1'b1}};
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = S_CALC;
                        r_d     = {WIDTH{1'b0}};
                        q_d     = dvd_mag_s;
                        dsr_d   = dsr_mag_s;
                        cnt_d   = {CW{1'b0}};
`ifdef SEQ_CLA_DIVIDER_SIGNED_EN
                        qneg_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        rneg_d  = dividend[WIDTH-1];
`endif
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                r_d   = r_new_s;
                q_d   = q_new_s;
                cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                if (cnt_q == LAST) begin
`ifdef SEQ_CLA_DIVIDER_SIGNED_EN
                    state_d = S_FIX;
`else
                    state_d = S_DONE;
                    quo_d   = q_new_s;
                    rem_d   = r_new_s;
                    dbz_d   = 1'b0;
`endif
                end else begin
                    state_d = S_CALC;
                end
            end
`ifdef SEQ_CLA_DIVIDER_SIGNED_EN
            S_FIX: begin
                state_d = S_DONE;
                quo_d   = qneg_q ? negate(q_q) : q_q;
                rem_d   = rneg_q ? negate(r_q) : r_q;
                dbz_d   = 1'b0;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy_d = (state_d == S_CALC);
`ifdef SEQ_CLA_DIVIDER_SIGNED_EN
        busy_d = busy_d | (state_d == S_FIX);
`endif
        done_d = (state_d == S_DONE);
    end

    // State, working registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            r_q     <= {WIDTH{1'b0}};
            q_q     <= {WIDTH{1'b0}};
            dsr_q   <= {WIDTH{1'b0}};
            cnt_q   <= {CW{1'b0}};
            quo_q   <= {WIDTH{1'b0}};
            rem_q   <= {WIDTH{1'b0}};
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dsr_q   <= dsr_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule
